// File: rtl/execute_stage.sv
// Execute stage: six-lane 8-bit vector ALU with registered NZCV flags and a
// lane-parallel iterative restoring divider for the MOD operation.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | single-cycle ops; a MOD here loads the divider and stalls
// BUSY  | one restoring division step per cycle on every lane (W steps)
// DONE  | remainders presented on ALUResultE, writes and flags released
module execute_stage #(
    parameter int LANES = 6,
    parameter int W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWriteE,
    input  logic                 MemtoRegE,
    input  logic                 MemWriteE,
    input  logic                 ALUSrcE,
    input  logic                 FlagsWriteE,
    input  logic [2:0]           ALUControlE,
    input  logic [3:0]           WA3E,
    input  logic [LANES*W-1:0]   rd1E,
    input  logic [LANES*W-1:0]   rd2E,
    input  logic [W-1:0]         ExtImmE,
    output logic [LANES*W-1:0]   ALUResultE,
    output logic [LANES*W-1:0]   WriteDataE,
    output logic [3:0]           FlagsE,
    output logic                 StallE,
    output logic                 RegWriteGE,
    output logic                 MemWriteGE,
    output logic                 MemtoRegGE,
    output logic [3:0]           WA3GE
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MOD  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MOVB = 3'b111;

    // Step counter width; also the number of shift-amount bits used by SHL.
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [LANES-1:0][W-1:0]     rem_q, rem_d;
    logic [LANES-1:0][W-1:0]     dvd_q, dvd_d;
    logic [LANES-1:0][W-1:0]     dsr_q, dsr_d;
    logic [3:0]                  flags_q, flags_d;

    logic [LANES-1:0][W-1:0]     op_a, op_b, alu_res, res_all;
    logic [LANES-1:0][W:0]       sum_l, dif_l;
    logic [LANES-1:0]            carry_l, borrow_l;
    logic [LANES-1:0][W:0]       rem_sh;
    logic [LANES-1:0][W-1:0]     rem_nx, dvd_nx;
    logic                        stall;
    logic                        flag_n, flag_z, flag_c, flag_v;

    // Lane operand selection and single-cycle ALU results.
    always_comb begin
        op_a     = '0;
        op_b     = '0;
        sum_l    = '0;
        dif_l    = '0;
        carry_l  = '0;
        borrow_l = '0;
        alu_res  = '0;
        for (int i = 0; i < LANES; i++) begin
            op_a[i]     = rd1E[i*W +: W];
            op_b[i]     = ALUSrcE ? ExtImmE : rd2E[i*W +: W];
            sum_l[i]    = {1'b0, op_a[i]} + {1'b0, op_b[i]};
            dif_l[i]    = {1'b0, op_a[i]} - {1'b0, op_b[i]};
            carry_l[i]  = sum_l[i][W];
            borrow_l[i] = dif_l[i][W];
            case (ALUControlE)
                OP_ADD:  alu_res[i] = sum_l[i][W-1:0];
                OP_SUB:  alu_res[i] = dif_l[i][W-1:0];
                OP_MUL:  alu_res[i] = op_a[i] * op_b[i];
                OP_AND:  alu_res[i] = op_a[i] & op_b[i];
                OP_OR:   alu_res[i] = op_a[i] | op_b[i];
                OP_SHL:  alu_res[i] = op_a[i] << op_b[i][CW-1:0];
                OP_MOVB: alu_res[i] = op_b[i];
                default: alu_res[i] = '0;  // remainder only valid in DONE
            endcase
        end
    end

    // One restoring division step per lane; a zero divisor always "fits",
    // so the dividend bits simply accumulate and the remainder ends as A.
    always_comb begin
        rem_sh = '0;
        rem_nx = '0;
        dvd_nx = '0;
        for (int i = 0; i < LANES; i++) begin
            rem_sh[i] = {rem_q[i], dvd_q[i][W-1]};
            if (rem_sh[i] >= {1'b0, dsr_q[i]}) begin
                // True difference is below the divisor, so W bits suffice.
                rem_nx[i] = rem_sh[i][W-1:0] - dsr_q[i];
                dvd_nx[i] = {dvd_q[i][W-2:0], 1'b1};
            end else begin
                rem_nx[i] = rem_sh[i][W-1:0];
                dvd_nx[i] = {dvd_q[i][W-2:0], 1'b0};
            end
        end
    end

    // Divider FSM next-state, datapath loads and the stall request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ALUControlE == OP_MOD) begin
                    stall   = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = op_a;
                    dsr_d   = op_b;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + CW'(1);
                rem_d = rem_nx;
                dvd_d = dvd_nx;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Unconditional return so a MOD still held here cannot restart.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Committing result and the NZCV value it would load.
    always_comb begin
        res_all = (state_q == S_DONE) ? rem_q : alu_res;
        flag_n  = res_all[0][W-1];
        flag_z  = ~|res_all;
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        if (state_q != S_DONE) begin
            if (ALUControlE == OP_ADD) begin
                flag_c = |carry_l;
                flag_v = (op_a[0][W-1] == op_b[0][W-1]) &&
                         (sum_l[0][W-1] != op_a[0][W-1]);
            end else if (ALUControlE == OP_SUB) begin
                flag_c = |borrow_l;
                flag_v = (op_a[0][W-1] != op_b[0][W-1]) &&
                         (dif_l[0][W-1] != op_a[0][W-1]);
            end
        end
        flags_d = {flag_n, flag_z, flag_c, flag_v};
    end

    // FSM, divider and flags registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            if (FlagsWriteE && !stall) begin
                flags_q <= flags_d;
            end
        end
    end

    assign ALUResultE = res_all;
    assign WriteDataE = rd2E;
    assign FlagsE     = flags_q;
    assign StallE     = stall;
    assign RegWriteGE = RegWriteE & ~stall;
    assign MemWriteGE = MemWriteE & ~stall;
    assign MemtoRegGE = MemtoRegE;
    assign WA3GE      = WA3E;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the stimulus process queues expected
// commits and stall lengths; the monitor process checks whatever the DUT
// presents on each falling edge.
module tb_execute_stage;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MOD  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MOVB = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, FlagsWriteE;
    logic [2:0]  ALUControlE;
    logic [3:0]  WA3E;
    logic [47:0] rd1E, rd2E;
    logic [7:0]  ExtImmE;
    logic [47:0] ALUResultE, WriteDataE;
    logic [3:0]  FlagsE;
    logic        StallE, RegWriteGE, MemWriteGE, MemtoRegGE;
    logic [3:0]  WA3GE;

    typedef struct packed {
        logic [47:0] res;
        logic [47:0] wd;
        logic [3:0]  wa;
        logic [3:0]  flags;
        logic        mw;
        logic        m2r;
    } exp_t;

    exp_t exp_q[$];
    int   stall_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    execute_stage #(.LANES(6), .W(8)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .FlagsWriteE(FlagsWriteE), .ALUControlE(ALUControlE),
        .WA3E(WA3E), .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .FlagsE(FlagsE),
        .StallE(StallE), .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE),
        .MemtoRegGE(MemtoRegGE), .WA3GE(WA3GE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] bc(input logic [7:0] v);
        return {6{v}};
    endfunction

    function automatic logic [47:0] pk(input logic [7:0] l0, l1, l2, l3, l4, l5);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    // Drive one instruction for its full occupancy (10 cycles for MOD).
    task automatic issue(input logic [2:0] op, input logic [47:0] a, input logic [47:0] b,
                         input logic src, input logic [7:0] imm, input logic fw,
                         input logic [3:0] wa, input logic [47:0] eres, input logic [3:0] eflags);
        exp_t e;
        ALUControlE = op;
        rd1E        = a;
        rd2E        = b;
        ALUSrcE     = src;
        ExtImmE     = imm;
        FlagsWriteE = fw;
        WA3E        = wa;
        RegWriteE   = 1'b1;
        MemWriteE   = (op == OP_MOD);
        MemtoRegE   = wa[0];
        e.res   = eres;
        e.wd    = b;
        e.wa    = wa;
        e.flags = eflags;
        e.mw    = (op == OP_MOD);
        e.m2r   = wa[0];
        exp_q.push_back(e);
        if (op == OP_MOD) begin
            stall_q.push_back(9);
            repeat (10) @(posedge clk);
        end else begin
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor: stall-window length, gated writes, commits and flag updates.
    initial begin
        int         stall_run = 0;
        logic       pend = 1'b0;
        logic [3:0] pend_flags = 4'b0;
        logic       known = 1'b0;
        logic [3:0] cur_flags = 4'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("flags_after_commit", 64'(FlagsE), 64'(pend_flags));
                cur_flags = pend_flags;
                known     = 1'b1;
                pend      = 1'b0;
            end
            if (StallE === 1'b1) begin
                stall_run++;
                chk("gated_writes_in_stall", 64'({RegWriteGE, MemWriteGE}), 64'(0));
                if (known) chk("flags_hold_in_stall", 64'(FlagsE), 64'(cur_flags));
            end else begin
                if (stall_run > 0) begin
                    if (stall_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL stall_unexpected: got %0d cycles expected none", stall_run);
                    end else begin
                        chk("stall_len", 64'(stall_run), 64'(stall_q.pop_front()));
                    end
                    stall_run = 0;
                end
                if (RegWriteGE === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL commit_unexpected: got result %0h expected no commit", ALUResultE);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", 64'(ALUResultE), 64'(e.res));
                        chk("write_data", 64'(WriteDataE), 64'(e.wd));
                        chk("wa3", 64'(WA3GE), 64'(e.wa));
                        chk("memwrite_g", 64'(MemWriteGE), 64'(e.mw));
                        chk("memtoreg_g", 64'(MemtoRegGE), 64'(e.m2r));
                        pend       = 1'b1;
                        pend_flags = e.flags;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
        ALUSrcE = 1'b0; FlagsWriteE = 1'b0; ALUControlE = OP_ADD; WA3E = 4'd0;
        rd1E = '0; rd2E = '0; ExtImmE = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 64'(FlagsE), 64'(0));
        chk("reset_stall", 64'(StallE), 64'(0));
        reset = 1'b0;

        //     op       A                          B                            src imm    fw wa    result                          NZCV
        issue(OP_ADD,  bc(8'hF0),                 bc(8'h20),                   0, 8'h00, 1, 4'd1, bc(8'h10),                      4'b0010);
        issue(OP_SUB,  bc(8'h05),                 bc(8'hAA),                   1, 8'h05, 1, 4'd2, bc(8'h00),                      4'b0100);
        issue(OP_MUL,  bc(8'h10),                 bc(8'h11),                   0, 8'h00, 0, 4'd3, bc(8'h10),                      4'b0100);
        issue(OP_SHL,  bc(8'h81),                 bc(8'h33),                   1, 8'h09, 0, 4'd4, bc(8'h02),                      4'b0100);
        issue(OP_AND,  bc(8'hFF),                 pk(8'h8C,1,2,4,8,8'h10),     0, 8'h00, 1, 4'd5, pk(8'h8C,1,2,4,8,8'h10),        4'b1000);
        issue(OP_OR,   bc(8'h00),                 bc(8'h00),                   0, 8'h00, 1, 4'd6, bc(8'h00),                      4'b0100);
        issue(OP_MOVB, bc(8'hFF),                 bc(8'h01),                   1, 8'h7F, 1, 4'd7, bc(8'h7F),                      4'b0000);
        issue(OP_SUB,  bc(8'h10),                 bc(8'h20),                   0, 8'h00, 1, 4'd8, bc(8'hF0),                      4'b1010);
        issue(OP_MOD,  pk(200,17,255,9,0,100),    pk(7,17,16,0,3,255),         0, 8'h00, 1, 4'd9, pk(4,0,15,9,0,100),             4'b0000);
        issue(OP_MOD,  pk(200,255,128,77,1,250),  pk(201,2,3,10,1,251),        0, 8'h00, 1, 4'd10, pk(200,1,2,7,0,250),           4'b1000);
        issue(OP_ADD,  bc(8'h70),                 bc(8'h10),                   0, 8'h00, 1, 4'd11, bc(8'h80),                     4'b1001);

        // Modulo op abandoned by a two-cycle reset while its counter is at 4.
        ALUControlE = OP_MOD; rd1E = bc(8'd99); rd2E = bc(8'd7); ALUSrcE = 1'b0;
        FlagsWriteE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; WA3E = 4'd12;
        stall_q.push_back(6);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; ALUControlE = OP_ADD; RegWriteE = 1'b0; MemWriteE = 1'b0; FlagsWriteE = 1'b0;
        @(posedge clk);
        #1;
        chk("midmod_reset_flags", 64'(FlagsE), 64'(0));
        chk("midmod_reset_stall", 64'(StallE), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_flags", 64'(FlagsE), 64'(0));
        chk("post_reset_stall", 64'(StallE), 64'(0));
        issue(OP_ADD,  bc(8'hF0),                 bc(8'h20),                   0, 8'h00, 1, 4'd13, bc(8'h10),                     4'b0010);

        RegWriteE = 1'b0; MemWriteE = 1'b0; FlagsWriteE = 1'b0; ALUControlE = OP_ADD;
        repeat (3) @(posedge clk);
        #1;
        chk("commits_outstanding", 64'(exp_q.size()), 64'(0));
        chk("stalls_outstanding", 64'(stall_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the RSA pipeline CPU, downstream of the ID/EX pipeline register and feeding the EX/MEM register. It performs six-lane 8-bit vector ALU operations on the decoded operands and maintains a registered flags register. Single-cycle operations return their result in the same cycle. Lane-wise modular reduction (MOD, the core RSA primitive) runs as an 8-cycle iterative restoring divider that stalls the front of the pipeline.

## Interface
Parameters:
- LANES, 6, number of 8-bit vector lanes
- W, 8, lane width in bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  control bits from ID/EX
- ALUSrcE  in  1  1: operand B = ExtImmE broadcast to all lanes; 0: rd2E
- FlagsWriteE  in  1  update the flags register when the result commits
- ALUControlE  in  3  operation select
- WA3E  in  4  destination register, passed through unchanged
- rd1E, rd2E  in  LANES×W  operands A and B
- ExtImmE  in  W  immediate
- ALUResultE  out  LANES×W  lane results
- WriteDataE  out  LANES×W  equal to rd2E (store data)
- FlagsE  out  4  registered {N,Z,C,V}
- StallE  out  1  multicycle operation in progress; upstream stages and ID/EX must hold
- RegWriteGE, MemWriteGE  out  1 each  RegWriteE/MemWriteE gated low while StallE=1
- MemtoRegGE  out  1  MemtoRegE passthrough
- WA3GE  out  4  WA3E passthrough

## Operation
- B per lane = ALUSrcE ? ExtImmE : rd2E[i].
- ALUControlE encoding, all lane-wise and mod 2^W:
  - 000 ADD
  - 001 SUB (A−B)
  - 010 MUL, low W bits of A×B
  - 011 AND
  - 100 OR
  - 101 MOD: A mod B, multicycle
  - 110 SHL: A << B[2:0]
  - 111 MOVB: result = B
- FSM states:
  - IDLE: if ALUControlE==101, load the dividend/divisor shift registers for all lanes, set the counter to 0, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: perform one restoring step per cycle on all lanes in parallel and increment the counter. After the 8th step (counter==7), go to DONE.
  - DONE: present the remainders on ALUResultE, then go to IDLE unconditionally.
- Because DONE always returns to IDLE, a MOD that is still held on the inputs during DONE does not restart. Back-to-back MODs start from IDLE once the next instruction arrives.
- Divisor 0 in a lane: that lane's remainder = A. No trap.
- Flags are computed from the committing result:
  - N = lane0 bit W−1
  - Z = 1 iff all LANES×W result bits are 0
  - C = OR of lane carry-outs (ADD) or lane borrows (SUB); 0 for other ops
  - V = lane0 signed overflow for ADD/SUB; 0 for other ops
- Flags register loads only when FlagsWriteE=1 and StallE=0. It holds otherwise.
- Gated outputs suppress the writes of a stalled MOD until its DONE cycle.

## Timing
- Reset, sampled at the rising edge, takes effect on the same edge:
  - FSM → IDLE, counter = 0, FlagsE = 0000, StallE = 0
  - Shift registers are cleared to 0
- Reset during BUSY or DONE abandons the operation; no flag update occurs.
- Single-cycle ops: ALUResultE is combinational from the inputs (0 cycles). StallE = 0.
- MOD timing, with cycle 0 = the cycle MOD is first presented in IDLE:
  - StallE is combinational and high in cycle 0 (IDLE with ALUControlE==101) and cycles 1–8 (BUSY). That is 9 stall cycles.
  - Cycle 9 is DONE: StallE = 0, ALUResultE = remainder, gated writes enabled.
  - FlagsE updates at the end of cycle 9 if FlagsWriteE=1.
- ALUResultE during a stall is don't-care. Downstream must not consume it (RegWriteGE = MemWriteGE = 0).
- Inputs must stay stable while StallE=1; this is the hazard unit's responsibility. The divider uses its loaded copies, so input changes during BUSY do not corrupt the result.

## Test plan
- Reset: hold reset 2 cycles mid-MOD (counter=4) → next cycle StallE=0, FlagsE=0000, FSM in IDLE; a new ADD gives the correct result immediately.
- ADD, all lanes A=0xF0, B=0x20, FlagsWriteE=1 → ALUResultE lanes = 0x10; FlagsE = N0 Z0 C1 V0 after the edge.
- SUB with ALUSrcE=1, ExtImmE=0x05, all lanes A=0x05 → result all 0x00; Z=1, C=0.
- MOD, lanes A={200,17,255,9,0,100}, B={7,17,16,0,3,255} → StallE high exactly 9 cycles; DONE cycle result = {4,0,15,9,0,100}; RegWriteGE=1 only in DONE.
- Two consecutive MODs (next instruction presented in the cycle after DONE) → second StallE window starts immediately; no spurious restart during DONE.
- MUL 0x10×0x11 per lane → 0x10; SHL 0x81 by B=0x09 (uses B[2:0]=1) → 0x02; FlagsWriteE=0 → FlagsE unchanged.
